// File: rtl/ctrl_pkg.sv
// Shared types for the ALU control slice:
// opcodes, ALUop codes, FSM states, decoded bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] R_ADD = 4'b0000;
  localparam logic [3:0] R_SUB = 4'b0001;
  localparam logic [3:0] R_XOR = 4'b0010;
  localparam logic [3:0] R_OR  = 4'b0011;
  localparam logic [3:0] R_AND = 4'b0100;
  localparam logic [3:0] R_SLL = 4'b0101;
  localparam logic [3:0] R_SRL = 4'b0110;
  localparam logic [3:0] R_SRA = 4'b0111;

  localparam logic [3:0] I_ADDI = 4'b0000;
  localparam logic [3:0] I_XORI = 4'b0001;
  localparam logic [3:0] I_ORI  = 4'b0010;
  localparam logic [3:0] I_ANDI = 4'b0011;
  localparam logic [3:0] I_SLLI = 4'b0100;
  localparam logic [3:0] I_SRAI = 4'b0101;
  localparam logic [3:0] I_SRLI = 4'b0110;

  localparam logic [3:0] OP_ADDR = 4'b0000;
  localparam logic [3:0] OP_CMP  = 4'b0001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH
  } cls_e;

  // br: {beq, bne, blt, bge, bltu, bgeu}
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       sftmd;
    logic [5:0] br;
    cls_e       cls;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I subset decoder:
// instruction word to ALU control bundle.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Map opcode/funct3/funct7 to control fields.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opc)
      OP_R: begin
        ctrl.cls = CL_ALU;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000: ctrl.alu_op = R_ADD;
            3'b001: begin
              ctrl.alu_op = R_SLL;
              ctrl.sftmd  = 1'b1;
            end
            3'b100: ctrl.alu_op = R_XOR;
            3'b101: begin
              ctrl.alu_op = R_SRL;
              ctrl.sftmd  = 1'b1;
            end
            3'b110: ctrl.alu_op = R_OR;
            3'b111: ctrl.alu_op = R_AND;
            default: illegal = 1'b1;
          endcase
        end else if (f7 == 7'h20) begin
          case (f3)
            3'b000: ctrl.alu_op = R_SUB;
            3'b101: begin
              ctrl.alu_op = R_SRA;
              ctrl.sftmd  = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        ctrl.cls     = CL_ALU;
        ctrl.alu_src = 1'b1;
        case (f3)
          3'b000: ctrl.alu_op = I_ADDI;
          3'b100: ctrl.alu_op = I_XORI;
          3'b110: ctrl.alu_op = I_ORI;
          3'b111: ctrl.alu_op = I_ANDI;
          3'b001: begin
            ctrl.alu_op = I_SLLI;
            ctrl.sftmd  = 1'b1;
            illegal     = (f7 != 7'h00);
          end
          3'b101: begin
            ctrl.sftmd = 1'b1;
            if (f7 == 7'h00)
              ctrl.alu_op = I_SRLI;
            else if (f7 == 7'h20)
              ctrl.alu_op = I_SRAI;
            else
              illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.cls     = CL_LOAD;
        ctrl.alu_op  = OP_ADDR;
        ctrl.alu_src = 1'b1;
        illegal      = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        ctrl.cls     = CL_STORE;
        ctrl.alu_op  = OP_ADDR;
        ctrl.alu_src = 1'b1;
        illegal      = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        ctrl.cls    = CL_BRANCH;
        ctrl.alu_op = OP_CMP;
        case (f3)
          3'b000: ctrl.br = 6'b100000;
          3'b001: ctrl.br = 6'b010000;
          3'b100: ctrl.br = 6'b001000;
          3'b101: ctrl.br = 6'b000100;
          3'b110: ctrl.br = 6'b000010;
          3'b111: ctrl.br = 6'b000001;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control unit: fetch, decode,
// execute, memory and writeback sequencing.
module alu_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter bit          RESET_PC_SEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        branch_result,
  input  logic        dmem_ready,
  output logic [3:0]  ALUop,
  output logic        ALUSrc,
  output logic        sftmd,
  output logic        Branch,
  output logic        nBranch,
  output logic        Branch_lt,
  output logic        Branch_ge,
  output logic        Branch_ltu,
  output logic        Branch_geu,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        illegal
);

  // Wait counter value on the last allowed cycle.
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  state_e      state, state_n;
  logic [31:0] ir;
  logic [3:0]  cnt, cnt_n;
  ctrl_t       ctrl_q, dec;
  logic        dec_ill;

  alu_op_decode u_dec (
    .instr   (ir),
    .ctrl    (dec),
    .illegal (dec_ill)
  );

  assign ALUop  = ctrl_q.alu_op;
  assign ALUSrc = ctrl_q.alu_src;
  assign sftmd  = ctrl_q.sftmd;
  assign {Branch, nBranch, Branch_lt,
          Branch_ge, Branch_ltu,
          Branch_geu} = ctrl_q.br;

  // State, wait counter, IR and decoded fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      cnt    <= '0;
      ir     <= '0;
      ctrl_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_FETCH && instr_valid)
        ir <= instr;
      if (state == S_DECODE)
        ctrl_q <= dec_ill ? '0 : dec;
      else if (state_n == S_FETCH ||
               state_n == S_TRAP)
        ctrl_q <= '0;
    end
  end

  // Next state, counter and strobes.
  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    instr_ready = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_n = S_DECODE;
        else if (cnt == TMO_LAST)
          state_n = S_TRAP;
        else
          cnt_n = cnt + 4'd1;
      end
      S_DECODE: begin
        state_n = dec_ill ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (ctrl_q.cls)
          CL_BRANCH: begin
            pc_src  = branch_result;
            pc_we   = 1'b1;
            state_n = S_FETCH;
          end
          CL_LOAD, CL_STORE: state_n = S_MEM;
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (ctrl_q.cls == CL_LOAD);
        mem_write = (ctrl_q.cls == CL_STORE);
        // Completion beats a same-cycle timeout.
        if (dmem_ready) begin
          if (ctrl_q.cls == CL_LOAD) begin
            state_n = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_n = S_FETCH;
          end
        end else if (cnt == TMO_LAST) begin
          state_n = S_TRAP;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        mem_to_reg = (ctrl_q.cls == CL_LOAD);
        state_n    = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_n = S_FETCH;
    endcase
    if (rst)
      pc_src = RESET_PC_SEL;
  end

endmodule
